// File: rtl/inst_fetch.sv
// Instruction-fetch stage: holds the PC, reads instruction memory over req/ack,
// latches the word into Inst and computes the next PC from control redirects.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_addr,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic        inst_valid,
  output logic [31:0] Inst,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic {
    FETCH,
    VALID
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] next_pc;
  logic [31:0] branch_off;

  assign pc_plus4   = pc_q + 32'd4;
  assign branch_off = {{14{branch_imm[15]}}, branch_imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = jr_target & 32'hFFFF_FFFC;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], jump_addr, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  // Acks are only honoured in FETCH; redirects only on consume (VALID & !stall).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    case (state_q)
      FETCH: begin
        if (imem_ack) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = VALID;
        end
      end
      VALID: begin
        if (!stall) begin
          pc_d         = next_pc;
          inst_valid_d = 1'b0;
          state_d      = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign imem_req   = (state_q == FETCH) && !rst;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign Inst       = inst_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_addr;
  logic        jr;
  logic [31:0] jr_target;
  logic        inst_valid;
  logic [31:0] Inst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  bit          m_have;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall),
    .branch_taken(branch_taken), .branch_imm(branch_imm),
    .jump(jump), .jump_addr(jump_addr),
    .jr(jr), .jr_target(jr_target),
    .inst_valid(inst_valid), .Inst(Inst),
    .pc(pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Target address computed with wide signed arithmetic, reduced modulo 2^32.
  function automatic logic [31:0] model_target(input logic [31:0] cur);
    longint t;
    longint seq;
    seq = (longint'(cur) + 4) % 64'sd4294967296;
    if (jr)                t = longint'(jr_target) - (longint'(jr_target) % 4);
    else if (jump)         t = (seq / 268435456) * 268435456 + longint'(jump_addr) * 4;
    else if (branch_taken) t = seq + longint'($signed(branch_imm)) * 4;
    else                   t = seq;
    t = t % 64'sd4294967296;
    if (t < 0) t = t + 64'sd4294967296;
    return t[31:0];
  endfunction

  task automatic tick();
    logic [31:0] nxt;
    nxt = model_target(m_pc);
    @(posedge clk);
    if (rst) begin
      m_pc = RESET_PC; m_inst = '0; m_have = 0;
    end else if (!m_have) begin
      if (imem_ack) begin m_inst = imem_rdata; m_have = 1; end
    end else if (!stall) begin
      m_pc = nxt; m_have = 0;
    end
    #1;
    check("imem_req",   {31'd0, imem_req},   {31'd0, !rst && !m_have});
    check("imem_addr",  imem_addr,           m_pc);
    check("pc",         pc,                  m_pc);
    check("pc_plus4",   pc_plus4,            m_pc + 32'd4);
    check("inst_valid", {31'd0, inst_valid}, {31'd0, m_have});
    check("Inst",       Inst,                m_inst);
  endtask

  task automatic clear_redirects();
    branch_taken = 0; branch_imm = '0; jump = 0; jump_addr = '0; jr = 0; jr_target = '0;
  endtask

  task automatic fetch(input logic [31:0] word);
    imem_ack = 1; imem_rdata = word;
    tick();
    imem_ack = 0;
  endtask

  task automatic consume();
    stall = 0;
    tick();
    stall = 1;
    clear_redirects();
  endtask

  task automatic goto_pc(input logic [31:0] target);
    fetch(32'hDEAD_0000);
    jr = 1; jr_target = target;
    consume();
  endtask

  initial begin
    rst = 1; imem_ack = 0; imem_rdata = '0; stall = 1;
    clear_redirects();
    m_pc = '0; m_inst = '0; m_have = 0;
    tick(); tick();
    check("reset_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("reset_pc", pc, RESET_PC);

    // Scenario 1: first fetch after reset
    rst = 0;
    tick();
    check("s1_req", {31'd0, imem_req}, 32'd1);
    check("s1_addr", imem_addr, RESET_PC);
    fetch(32'h2002_0005);
    check("s1_inst", Inst, 32'h2002_0005);
    check("s1_valid", {31'd0, inst_valid}, 32'd1);
    check("s1_pc4", pc_plus4, RESET_PC + 32'd4);
    consume();

    // Scenario 2: branches from 0x100
    goto_pc(32'h0000_0100);
    fetch(32'h1111_1111);
    branch_taken = 1; branch_imm = 16'hFFFF;
    consume();
    check("s2_br_neg", imem_addr, 32'h0000_0100);
    fetch(32'h2222_2222);
    branch_taken = 1; branch_imm = 16'h0003;
    consume();
    check("s2_br_pos", imem_addr, 32'h0000_0110);

    // Scenario 3: jump, then jr overriding jump
    goto_pc(32'h9000_0000);
    fetch(32'h0800_0040);
    jump = 1; jump_addr = 26'h40;
    consume();
    check("s3_jump", imem_addr, 32'h9000_0100);
    fetch(32'h0000_0008);
    jump = 1; jump_addr = 26'h40; jr = 1; jr_target = 32'h0000_2003;
    consume();
    check("s3_jr_wins", imem_addr, 32'h0000_2000);

    // Scenario 4: stall with stray ack and redirects, then delayed ack
    fetch(32'hABCD_1234);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1; imem_rdata = 32'h5555_AAAA; jr = 1; jr_target = 32'h4000_0000;
      tick();
    end
    imem_ack = 0; clear_redirects();
    check("s4_stall_inst", Inst, 32'hABCD_1234);
    check("s4_stall_pc", pc, 32'h0000_2000);
    consume();
    check("s4_seq", imem_addr, 32'h0000_2004);
    for (int i = 0; i < 5; i++) tick();
    check("s4_delay_addr", imem_addr, 32'h0000_2004);
    check("s4_delay_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h0F0F_0F0F);
    consume();

    // Scenario 5: sequential wrap at top of address space
    goto_pc(32'hFFFF_FFFC);
    fetch(32'h7777_7777);
    consume();
    check("s5_wrap", imem_addr, 32'h0000_0000);

    // Scenario 6: reset while waiting on ack, with ack in the reset cycle
    goto_pc(32'h0000_0400);
    tick();
    rst = 1; imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    check("s6_req", {31'd0, imem_req}, 32'd0);
    check("s6_valid", {31'd0, inst_valid}, 32'd0);
    rst = 0; imem_ack = 0;
    tick();
    check("s6_refetch", imem_addr, RESET_PC);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      rst          = ($urandom_range(0, 99) < 2);
      imem_ack     = $urandom_range(0, 1) == 1;
      imem_rdata   = $urandom;
      stall        = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 2) == 0);
      branch_imm   = 16'($urandom);
      jump         = ($urandom_range(0, 3) == 0);
      jump_addr    = 26'($urandom);
      jr           = ($urandom_range(0, 4) == 0);
      jr_target    = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
